// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker
//   Turns the predictor counter at IF into a taken decision, carries the
//   prediction through ID and EX, compares it with the EX outcome, flushes
//   ID/EX and redirects fetch on a mispredict, and emits one predictor-update
//   strobe per resolved branch.
//   Optional feature macro: BRT_PERF_CNT_EN (adds branch / mispredict counters).
//   Handshake: a branch in EX is resolved in any cycle where resolve_valid_ex=1;
//   update_en is a single-cycle strobe with no back-pressure, and a branch held
//   in EX by PL_stall is trained only once (update_done remembers it).
//   dbg_state exposes the FSM state (0=RUN, 1=RECOVER).
module branch_resolve_tracker #(
  parameter int JUMP_STATUS_COUNTER_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 is_branch_if,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count,
  input  logic [31:0]                          pc,
  input  logic                                 resolve_valid_ex,
  input  logic                                 actual_taken_ex,
  input  logic [31:0]                          target_ex,
  output logic                                 pred_taken_if,
  output logic                                 mispredict_ex,
  output logic [31:0]                          redirect_pc,
  output logic                                 update_en,
  output logic                                 update_taken,
  output logic [31:0]                          pc_ex,
`ifdef BRT_PERF_CNT_EN
  output logic [31:0]                          perf_branch_cnt,
  output logic [31:0]                          perf_mispredict_cnt,
`endif
  output logic                                 dbg_state
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_id_valid;
  logic        r_id_pred;
  logic [31:0] r_id_pc;
  logic        r_ex_valid;
  logic        r_ex_pred;
  logic [31:0] r_ex_pc;
  logic        r_update_done;

  logic        w_run;
  logic        w_if_valid;
  logic        w_if_pred;
  logic        w_resolve;
  logic        w_mispredict;

  // IF slot: only real branches fetched on the correct path are tracked
  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_if_valid   = is_branch_if & w_run;
    w_if_pred    = w_if_valid & HP_count[JUMP_STATUS_COUNTER_WIDTH-1];
    w_resolve    = r_ex_valid & resolve_valid_ex & ~r_update_done;
    w_mispredict = w_resolve & (actual_taken_ex != r_ex_pred);
  end

  // Outputs; combinational paths are forced to 0 while reset is asserted
  always_comb begin
    pred_taken_if = rst_n & w_if_pred;
    mispredict_ex = w_mispredict;
    update_en     = w_resolve;
    update_taken  = rst_n & actual_taken_ex;
    pc_ex         = r_ex_pc;
    redirect_pc   = 32'd0;
    if (rst_n) begin
      redirect_pc = actual_taken_ex ? target_ex : (r_ex_pc + 32'd4);
    end
    dbg_state     = r_state;
  end

  // ID/EX stage registers: advance when not stalled, flush overrides stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_pred  <= 1'b0;
      r_id_pc    <= 32'd0;
      r_ex_valid <= 1'b0;
      r_ex_pred  <= 1'b0;
      r_ex_pc    <= 32'd0;
    end else begin
      if (!PL_stall) begin
        r_id_valid <= w_if_valid;
        r_id_pred  <= w_if_pred;
        r_id_pc    <= pc;
        r_ex_valid <= r_id_valid;
        r_ex_pred  <= r_id_pred;
        r_ex_pc    <= r_id_pc;
      end
      if (w_mispredict) begin
        r_id_valid <= 1'b0;
        r_ex_valid <= 1'b0;
      end
    end
  end

  // Remember that the branch held in EX has already trained the predictor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_update_done <= 1'b0;
    end else if (!PL_stall) begin
      r_update_done <= 1'b0;
    end else if (w_resolve) begin
      r_update_done <= 1'b1;
    end
  end

  // RUN/RECOVER: after a mispredict the fetch slot is wrong path until a non-stalled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:     if (w_mispredict) r_state <= ST_RECOVER;
        ST_RECOVER: if (!PL_stall)    r_state <= ST_RUN;
        default:                      r_state <= ST_RUN;
      endcase
    end
  end

`ifdef BRT_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_cnt     <= 32'd0;
      perf_mispredict_cnt <= 32'd0;
    end else begin
      if (w_resolve)    perf_branch_cnt     <= perf_branch_cnt + 32'd1;
      if (w_mispredict) perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Bench for branch_resolve_tracker: each issued branch pushes its expected
// {mispredict, taken, pc, redirect} record; the record is popped and compared
// when update_en fires. Inputs change 1ns after posedge, outputs are sampled
// on the negedge.
module tb_branch_resolve_tracker;

  logic        clk;
  logic        rst_n;
  logic        PL_stall;
  logic        is_branch_if;
  logic [1:0]  HP_count;
  logic [31:0] pc;
  logic        resolve_valid_ex;
  logic        actual_taken_ex;
  logic [31:0] target_ex;
  logic        pred_taken_if;
  logic        mispredict_ex;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic        update_taken;
  logic [31:0] pc_ex;
  logic        dbg_state;
`ifdef BRT_PERF_CNT_EN
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_mispredict_cnt;
`endif

  localparam int W = 66;
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_br_cnt = 0;
  int exp_mis_cnt = 0;

  branch_resolve_tracker #(.JUMP_STATUS_COUNTER_WIDTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PL_stall         (PL_stall),
    .is_branch_if     (is_branch_if),
    .HP_count         (HP_count),
    .pc               (pc),
    .resolve_valid_ex (resolve_valid_ex),
    .actual_taken_ex  (actual_taken_ex),
    .target_ex        (target_ex),
    .pred_taken_if    (pred_taken_if),
    .mispredict_ex    (mispredict_ex),
    .redirect_pc      (redirect_pc),
    .update_en        (update_en),
    .update_taken     (update_taken),
    .pc_ex            (pc_ex),
`ifdef BRT_PERF_CNT_EN
    .perf_branch_cnt     (perf_branch_cnt),
    .perf_mispredict_cnt (perf_mispredict_cnt),
`endif
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // move to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PL_stall         = 1'b0;
    is_branch_if     = 1'b0;
    HP_count         = 2'b00;
    resolve_valid_ex = 1'b0;
    actual_taken_ex  = 1'b0;
  endtask

  // Issue one branch, resolve it two cycles later with nstall stalled cycles
  task automatic run_branch(input logic [31:0] bpc, input logic [1:0] hp,
                            input logic act, input logic [31:0] tgt, input int nstall);
    logic        pred;
    logic        mis;
    logic [31:0] redir;
    logic [W-1:0] rec;
    int          n_upd;
    int          n_mis;
    pred  = hp[1];
    mis   = (act != pred);
    redir = act ? tgt : (bpc + 32'd4);
    // IF cycle
    idle_inputs();
    is_branch_if = 1'b1;
    HP_count     = hp;
    pc           = bpc;
    #4;
    check("pred_taken_if", {31'd0, pred_taken_if}, {31'd0, pred});
    exp_q.push_back({mis, act, bpc, redir});
    exp_br_cnt++;
    if (mis) exp_mis_cnt++;
    tick();
    // ID cycle
    is_branch_if = 1'b0;
    pc           = $urandom;
    tick();
    // EX cycles
    n_upd = 0;
    n_mis = 0;
    for (int k = 0; k <= nstall; k++) begin
      PL_stall         = (k < nstall);
      resolve_valid_ex = 1'b1;
      actual_taken_ex  = act;
      target_ex        = tgt;
      is_branch_if     = mis && (k >= 1);
      HP_count         = 2'b11;
      #4;
      if (mis && k >= 1) begin
        check("state_recover_stalled", {31'd0, dbg_state}, 32'd1);
        check("pred_taken_if_recover", {31'd0, pred_taken_if}, 32'd0);
      end
      if (update_en) begin
        n_upd++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          rec = exp_q.pop_front();
          check("update_taken", {31'd0, update_taken}, {31'd0, rec[64]});
          check("pc_ex", pc_ex, rec[63:32]);
          check("mispredict_ex", {31'd0, mispredict_ex}, {31'd0, rec[65]});
          if (rec[65]) check("redirect_pc", redirect_pc, rec[31:0]);
        end
      end
      if (mispredict_ex) n_mis++;
      tick();
    end
    check("update_pulses", n_upd, 32'd1);
    check("mispredict_pulses", n_mis, {31'd0, mis});
    idle_inputs();
    if (mis && nstall == 0) begin
      is_branch_if = 1'b1;
      HP_count     = 2'b11;
      #4;
      check("state_recover", {31'd0, dbg_state}, 32'd1);
      check("pred_taken_if_recover", {31'd0, pred_taken_if}, 32'd0);
      tick();
      idle_inputs();
    end
    // bubbles resolving in EX must never train or redirect
    for (int k = 0; k < 2; k++) begin
      resolve_valid_ex = 1'b1;
      actual_taken_ex  = 1'($urandom_range(0, 1));
      #4;
      check("idle_update_en", {31'd0, update_en}, 32'd0);
      check("idle_mispredict", {31'd0, mispredict_ex}, 32'd0);
      check("idle_state_run", {31'd0, dbg_state}, 32'd0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [1:0]  hp;
    logic        act;
    // reset values with hostile inputs
    rst_n            = 1'b0;
    PL_stall         = 1'b0;
    is_branch_if     = 1'b1;
    HP_count         = 2'b11;
    pc               = 32'h100;
    resolve_valid_ex = 1'b1;
    actual_taken_ex  = 1'b1;
    target_ex        = 32'h1234;
    #3;
    check("rst_pred_taken_if", {31'd0, pred_taken_if}, 32'd0);
    check("rst_update_en", {31'd0, update_en}, 32'd0);
    check("rst_update_taken", {31'd0, update_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict_ex}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_pc_ex", pc_ex, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // asynchronous reset while a branch sits in EX
    is_branch_if = 1'b1;
    HP_count     = 2'b11;
    pc           = 32'h500;
    tick();
    idle_inputs();
    tick();
    resolve_valid_ex = 1'b1;
    actual_taken_ex  = 1'b0;
    target_ex        = 32'h900;
    #1;
    check("pre_reset_mispredict", {31'd0, mispredict_ex}, 32'd1);
    #1;
    rst_n           = 1'b0;
    actual_taken_ex = 1'b1;
    is_branch_if    = 1'b1;
    #1;
    check("mid_rst_update_en", {31'd0, update_en}, 32'd0);
    check("mid_rst_mispredict", {31'd0, mispredict_ex}, 32'd0);
    check("mid_rst_redirect_pc", redirect_pc, 32'd0);
    check("mid_rst_pc_ex", pc_ex, 32'd0);
    check("mid_rst_update_taken", {31'd0, update_taken}, 32'd0);
    check("mid_rst_pred_taken_if", {31'd0, pred_taken_if}, 32'd0);
    tick();
    rst_n        = 1'b1;
    is_branch_if = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resolve_valid_ex = 1'b1;
      #4;
      check("post_rst_update_en", {31'd0, update_en}, 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // directed cases
    run_branch(32'h0000_0100, 2'b11, 1'b1, 32'h0000_0180, 0);
    run_branch(32'h0000_0200, 2'b01, 1'b1, 32'h0000_0300, 0);
    run_branch(32'hFFFF_FFFC, 2'b10, 1'b0, 32'h0000_0040, 0);
    run_branch(32'h0000_0400, 2'b11, 1'b0, 32'h0000_0800, 3);
    run_branch(32'h0000_0404, 2'b00, 1'b0, 32'h0000_0900, 3);
    run_branch(32'h0000_0408, 2'b10, 1'b1, 32'h0000_0a00, 1);

    // ten branches, three of them mispredicted
    for (int i = 0; i < 10; i++) begin
      hp  = 2'($urandom_range(0, 3));
      act = ((i % 3 == 0) && (i < 9)) ? ~hp[1] : hp[1];
      run_branch(32'h1000 + 32'(i * 4), hp, act, 32'($urandom) & 32'hFFFF_FFFC,
                 $urandom_range(0, 2));
    end

    // random branches
    for (int i = 0; i < 30; i++) begin
      run_branch(32'($urandom) & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
                 $urandom_range(0, 3));
    end

    check("sb_leftover", exp_q.size(), 32'd0);
`ifdef BRT_PERF_CNT_EN
    #4;
    check("perf_branch_cnt", perf_branch_cnt, exp_br_cnt);
    check("perf_mispredict_cnt", perf_mispredict_cnt, exp_mis_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
